// File: rtl/way_state_array.sv
`default_nettype none
// ============================================================================
// Module   : way_state_array
// Brief    : Per-set, per-way state store with init sweep, forwarding, and
//            optional field parity (WAY_STATE_PARITY_EN).
// Revision : 1.0
// ============================================================================
module way_state_array #(
  parameter int            WAYS     = 4,
  parameter int            FW       = 3,
  parameter int            SETS     = 8192,
  parameter int            AW       = 13,
  parameter logic [FW-1:0] INIT_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 init_busy,
  input  logic                 re,
  input  logic [AW-1:0]        ra,
  input  logic [WAYS-1:0]      rwaysel,
  output logic [WAYS*FW-1:0]   rdallways,
  output logic [FW-1:0]        rd,
  output logic                 rd_vld,
  input  logic                 wr,
  input  logic [AW-1:0]        wa,
  input  logic [WAYS-1:0]      wwaysel,
  input  logic [FW-1:0]        wd
`ifdef WAY_STATE_PARITY_EN
  ,
  output logic                 par_err
`endif
);

`ifdef WAY_STATE_PARITY_EN
  localparam int c_sw = FW + 1;
`else
  localparam int c_sw = FW;
`endif
  localparam logic [AW-1:0] c_last = AW'(SETS - 1);

  typedef logic [c_sw-1:0] field_t;

  // Stored field is {even parity, data} when parity is enabled.
  function automatic field_t f_mk(input logic [FW-1:0] d);
`ifdef WAY_STATE_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [AW-1:0]       r_cnt, w_cnt_nxt;
  field_t              r_mem [SETS][WAYS];

  logic                w_we;
  logic [AW-1:0]       w_waddr;
  logic [WAYS-1:0]     w_wmask;
  logic [FW-1:0]       w_wdata;
  field_t              w_wfield;
  logic                w_wa_ok, w_ra_ok;

  field_t              w_rfield [WAYS];
  logic [WAYS*FW-1:0]  w_all;
  logic [FW-1:0]       w_sel;

  logic                r_rd_vld;
  logic [WAYS*FW-1:0]  r_rdallways;
  logic [FW-1:0]       r_rd;

  // Address range checks only exist when the address space exceeds SETS.
  if (2**AW > SETS) begin : g_addr_chk
    assign w_wa_ok = (wa <= c_last);
    assign w_ra_ok = (ra <= c_last);
  end else begin : g_addr_full
    assign w_wa_ok = 1'b1;
    assign w_ra_ok = 1'b1;
  end

  // The init sweep borrows the single write port.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_we        = 1'b0;
    w_waddr     = wa;
    w_wmask     = wwaysel;
    w_wdata     = wd;
    case (r_state)
      ST_INIT: begin
        w_we      = 1'b1;
        w_waddr   = r_cnt;
        w_wmask   = '1;
        w_wdata   = INIT_VAL;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == c_last) w_state_nxt = ST_RUN;
      end
      ST_RUN:  w_we = wr && w_wa_ok;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  assign w_wfield = f_mk(w_wdata);

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < WAYS; i++) begin
        if (w_wmask[i]) r_mem[w_waddr][i] <= w_wfield;
      end
    end
  end

  always_comb begin
    w_all = '0;
    w_sel = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (!w_ra_ok)
        w_rfield[i] = f_mk(INIT_VAL);
      else if (w_we && (w_waddr == ra) && w_wmask[i])
        w_rfield[i] = w_wfield;
      else
        w_rfield[i] = r_mem[ra][i];
    end
    // Scan downward so the lowest selected way has the last word.
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (rwaysel[i]) w_sel = w_rfield[i][FW-1:0];
    end
    for (int i = 0; i < WAYS; i++) begin
      w_all[i*FW +: FW] = w_rfield[i][FW-1:0];
    end
  end

`ifdef WAY_STATE_PARITY_EN
  logic w_perr;
  logic r_par_err;

  always_comb begin
    w_perr = 1'b0;
    for (int i = 0; i < WAYS; i++) w_perr = w_perr | (^w_rfield[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_par_err <= 1'b0;
    else if (re && r_state == ST_RUN)  r_par_err <= w_perr;
  end

  assign par_err = r_par_err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_rd_vld    <= 1'b0;
      r_rdallways <= '0;
      r_rd        <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rd_vld <= re && (r_state == ST_RUN);
      if (re && r_state == ST_RUN) begin
        r_rdallways <= w_all;
        r_rd        <= w_sel;
      end
    end
  end

  assign init_busy = (r_state == ST_INIT);
  assign rd_vld    = r_rd_vld;
  assign rdallways = r_rdallways;
  assign rd        = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_way_state_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_way_state_array
// Brief    : Vector table, randomized model comparison, reset/sweep sequences.
// Revision : 1.0
// ============================================================================
module tb_way_state_array;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_busy;
  logic        re;
  logic [12:0] ra;
  logic [3:0]  rwaysel;
  logic [11:0] rdallways;
  logic [2:0]  rd;
  logic        rd_vld;
  logic        wr;
  logic [12:0] wa;
  logic [3:0]  wwaysel;
  logic [2:0]  wd;
`ifdef WAY_STATE_PARITY_EN
  logic        par_err;
`endif

  always #5 clk = ~clk;

  way_state_array dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_busy (init_busy),
    .re        (re),
    .ra        (ra),
    .rwaysel   (rwaysel),
    .rdallways (rdallways),
    .rd        (rd),
    .rd_vld    (rd_vld),
    .wr        (wr),
    .wa        (wa),
    .wwaysel   (wwaysel),
    .wd        (wd)
`ifdef WAY_STATE_PARITY_EN
    ,
    .par_err   (par_err)
`endif
  );

  typedef struct packed {
    logic        wr;
    logic [12:0] wa;
    logic [3:0]  ws;
    logic [2:0]  wd;
    logic        re;
    logic [12:0] ra;
    logic [3:0]  rs;
    logic        vld;
    logic [11:0] all;
    logic [2:0]  rd;
  } vec_t;

  vec_t        tbl [13];
  logic [2:0]  model [8192][4];
  logic        exp_vld;
  logic [11:0] exp_all;
  logic [2:0]  exp_rd;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 8192; s++)
      for (int w = 0; w < 4; w++) model[s][w] = 3'd0;
  endtask

  // Drives one cycle and advances the reference model by the stated rules.
  task automatic step(input logic s_wr, input logic [12:0] s_wa, input logic [3:0] s_ws,
                      input logic [2:0] s_wd, input logic s_re, input logic [12:0] s_ra,
                      input logic [3:0] s_rs);
    wr = s_wr; wa = s_wa; wwaysel = s_ws; wd = s_wd;
    re = s_re; ra = s_ra; rwaysel = s_rs;
    if (s_re) begin
      exp_vld = 1'b1;
      for (int w = 0; w < 4; w++)
        exp_all[w*3 +: 3] = (s_wr && s_wa == s_ra && s_ws[w]) ? s_wd : model[s_ra][w];
      exp_rd = 3'd0;
      for (int w = 3; w >= 0; w--)
        if (s_rs[w]) exp_rd = exp_all[w*3 +: 3];
    end else begin
      exp_vld = 1'b0;
    end
    if (s_wr)
      for (int w = 0; w < 4; w++)
        if (s_ws[w]) model[s_wa][w] = s_wd;
    @(posedge clk); #1;
    wr = 1'b0; re = 1'b0;
  endtask

  // Runs until init_busy falls; re is held high to confirm reads are ignored.
  task automatic sweep(input int wr_at, output int n, output int bad);
    n = 0; bad = 0;
    re = 1'b1; ra = 13'd0; rwaysel = 4'b0001;
    while (init_busy && n < 20000) begin
      if (n == wr_at) begin
        wr = 1'b1; wa = 13'd5; wwaysel = 4'b1111; wd = 3'b111;
      end else begin
        wr = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (rd_vld !== 1'b0) bad++;
    end
    wr = 1'b0; re = 1'b0;
  endtask

  function automatic logic [12:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8)       return 13'(r);
    else if (r == 8) return 13'h1FFF;
    else             return 13'h0FFF;
  endfunction

  initial begin
    int n, bad;
    rst_n = 1'b0;
    wr = 1'b0; wa = '0; wwaysel = '0; wd = '0;
    re = 1'b0; ra = '0; rwaysel = '0;
    exp_vld = 1'b0; exp_all = '0; exp_rd = '0;
    model_clear();

    //         wr    wa        ws       wd      re    ra        rs       vld   all                rd
    tbl[0]  = '{1'b0, 13'h000, 4'b0000, 3'b000, 1'b1, 13'h000,  4'b0001, 1'b1, 12'b000000000000, 3'b000};
    tbl[1]  = '{1'b0, 13'h000, 4'b0000, 3'b000, 1'b1, 13'h0FFF, 4'b0001, 1'b1, 12'b000000000000, 3'b000};
    tbl[2]  = '{1'b0, 13'h000, 4'b0000, 3'b000, 1'b1, 13'h1FFF, 4'b0001, 1'b1, 12'b000000000000, 3'b000};
    tbl[3]  = '{1'b1, 13'h010, 4'b0101, 3'b110, 1'b0, 13'h000,  4'b0000, 1'b0, 12'b000000000000, 3'b000};
    tbl[4]  = '{1'b0, 13'h000, 4'b0000, 3'b000, 1'b1, 13'h010,  4'b0100, 1'b1, 12'b000110000110, 3'b110};
    tbl[5]  = '{1'b1, 13'h010, 4'b0000, 3'b111, 1'b1, 13'h010,  4'b0001, 1'b1, 12'b000110000110, 3'b110};
    tbl[6]  = '{1'b1, 13'h123, 4'b0111, 3'b001, 1'b0, 13'h000,  4'b0000, 1'b0, 12'b000110000110, 3'b110};
    tbl[7]  = '{1'b1, 13'h123, 4'b1000, 3'b111, 1'b1, 13'h123,  4'b1000, 1'b1, 12'b111001001001, 3'b111};
    tbl[8]  = '{1'b1, 13'h055, 4'b0010, 3'b010, 1'b0, 13'h000,  4'b0000, 1'b0, 12'b111001001001, 3'b111};
    tbl[9]  = '{1'b1, 13'h055, 4'b0100, 3'b101, 1'b0, 13'h000,  4'b0000, 1'b0, 12'b111001001001, 3'b111};
    tbl[10] = '{1'b0, 13'h000, 4'b0000, 3'b000, 1'b1, 13'h055,  4'b0110, 1'b1, 12'b000101010000, 3'b010};
    tbl[11] = '{1'b0, 13'h000, 4'b0000, 3'b000, 1'b1, 13'h055,  4'b0000, 1'b1, 12'b000101010000, 3'b000};
    tbl[12] = '{1'b0, 13'h000, 4'b0000, 3'b000, 1'b1, 13'h123,  4'b1111, 1'b1, 12'b111001001001, 3'b001};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_init_busy", 32'(init_busy), 32'd1);
    chk("reset_rd_vld",    32'(rd_vld),    32'd0);
    chk("reset_rdallways", 32'(rdallways), 32'd0);
    chk("reset_rd",        32'(rd),        32'd0);
`ifdef WAY_STATE_PARITY_EN
    chk("reset_par_err",   32'(par_err),   32'd0);
`endif

    rst_n = 1'b1;
    sweep(-1, n, bad);
    chk("sweep_length", 32'(n), 32'd8192);
    chk("sweep_rd_vld_low", 32'(bad), 32'd0);

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].wr, tbl[i].wa, tbl[i].ws, tbl[i].wd, tbl[i].re, tbl[i].ra, tbl[i].rs);
      chk($sformatf("vec%0d_rd_vld", i),    32'(rd_vld),    32'(tbl[i].vld));
      chk($sformatf("vec%0d_rdallways", i), 32'(rdallways), 32'(tbl[i].all));
      chk($sformatf("vec%0d_rd", i),        32'(rd),        32'(tbl[i].rd));
    end

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), pick_addr(), 4'($urandom), 3'($urandom),
           1'($urandom_range(0, 3) != 0), pick_addr(), 4'($urandom));
      chk("rand_rd_vld",    32'(rd_vld),    32'(exp_vld));
      chk("rand_rdallways", 32'(rdallways), 32'(exp_all));
      chk("rand_rd",        32'(rd),        32'(exp_rd));
    end

    // Reset during operation, then a one-cycle pulse at sweep count 100.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (init_busy !== 1'b1) bad++;
    end
    chk("early_sweep_busy", 32'(bad), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("pulse_init_busy", 32'(init_busy), 32'd1);
    chk("pulse_rd_vld",    32'(rd_vld),    32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sweep(200, n, bad);
    chk("resweep_length", 32'(n), 32'd8192);
    chk("resweep_rd_vld_low", 32'(bad), 32'd0);
    model_clear();
    step(1'b0, 13'd0, 4'd0, 3'd0, 1'b1, 13'd5, 4'b0001);
    chk("sweep_write_ignored_vld", 32'(rd_vld),    32'd1);
    chk("sweep_write_ignored",     32'(rdallways), 32'd0);
    step(1'b0, 13'd0, 4'd0, 3'd0, 1'b1, 13'h1FFF, 4'b1000);
    chk("resweep_last_set", 32'(rdallways), 32'd0);

`ifdef WAY_STATE_PARITY_EN
    dut.r_mem[5][2] = dut.r_mem[5][2] ^ 4'b0001;
    step(1'b0, 13'd0, 4'd0, 3'd0, 1'b1, 13'd5, 4'b0100);
    chk("par_err_vld",   32'(rd_vld),  32'd1);
    chk("par_err_flip",  32'(par_err), 32'd1);
    step(1'b0, 13'd0, 4'd0, 3'd0, 1'b1, 13'd6, 4'b0100);
    chk("par_err_clean", 32'(par_err), 32'd0);
    step(1'b1, 13'd7, 4'b0100, 3'b011, 1'b1, 13'd7, 4'b0100);
    chk("par_err_fwd",   32'(par_err), 32'd0);
    chk("par_fwd_rd",    32'(rd),      32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
